// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // Two's-complement negation; INT_MIN wraps onto itself.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/adder_module.sv
// Shared iteration adder/subtractor: Sel_i=0 adds, Sel_i=1 subtracts (C_o=1 means no borrow).
module adder_module #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Sel_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff     = Sel_i ? ~B_i : B_i;
  assign {C_o, S_o} = {1'b0, A_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Sel_i};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply, restoring divide, one step per clock.
// Optional macro MULDIV_KILL_EN adds kill_i to abort an in-flight operation.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
`ifdef MULDIV_KILL_EN
  ,
  input  logic             kill_i
`endif
);

  muldiv_state_e    state_reg;
  muldiv_op_e       op_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Request decode and operand magnitudes
  muldiv_op_e       op_in;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] special_res;

  assign op_in    = muldiv_op_e'(op_i);
  assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
  assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign a_neg    = a_signed && a_i[WIDTH-1];
  assign b_neg    = b_signed && b_i[WIDTH-1];
  assign a_mag    = a_neg ? neg32(a_i) : a_i;
  assign b_mag    = b_neg ? neg32(b_i) : b_i;
  assign div_zero = op_i[2] && (b_i == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (a_i == INT_MIN) && (b_i == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? a_i : DIV0_QUOT;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : INT_MIN;
    end
  end

  // Iteration datapath: the adder is shared between multiply add and divide trial subtract
  logic             is_div;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             no_borrow;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  assign is_div = op_reg[2];
  assign add_a  = is_div ? {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]} : hi_reg;

  adder_module #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A_i   (add_a),
    .B_i   (mcand_reg),
    .Sel_i (is_div),
    .S_o   (sum),
    .C_o   (carry)
  );

  // A set top bit of the old remainder means the shifted partial exceeds any 32-bit divisor.
  assign no_borrow = carry || hi_reg[WIDTH-1];

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (is_div) begin
      hi_next = no_borrow ? sum : add_a;
      lo_next = {lo_reg[WIDTH-2:0], no_borrow};
    end else if (lo_reg[0]) begin
      hi_next = {carry, sum[WIDTH-1:1]};
      lo_next = {sum[0], lo_reg[WIDTH-1:1]};
    end else begin
      hi_next = {1'b0, hi_reg[WIDTH-1:1]};
      lo_next = {hi_reg[0], lo_reg[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_res;

  assign prod_neg = ~{hi_reg, lo_reg} + 64'd1;

  always_comb begin
    fix_res = '0;
    case (op_reg)
      OP_MUL:             fix_res = lo_reg;
      OP_MULH, OP_MULHSU: fix_res = neg_q_reg ? prod_neg[2*WIDTH-1:WIDTH] : hi_reg;
      OP_MULHU:           fix_res = hi_reg;
      OP_DIV:             fix_res = neg_q_reg ? neg32(lo_reg) : lo_reg;
      OP_DIVU:            fix_res = lo_reg;
      OP_REM:             fix_res = neg_r_reg ? neg32(hi_reg) : hi_reg;
      OP_REMU:            fix_res = hi_reg;
      default:            fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_MUL;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      mcand_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_i) begin
            op_reg    <= op_in;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            hi_reg    <= '0;
            mcand_reg <= op_i[2] ? b_mag : a_mag;
            lo_reg    <= op_i[2] ? a_mag : b_mag;
            if (div_zero || div_ovf) begin
              result_reg <= special_res;
              state_reg  <= ST_DONE;
            end else begin
              cnt_reg   <= CNT_W'(MULDIV_ITER);
              state_reg <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_reg <= fix_res;
          state_reg  <= ST_DONE;
        end
        ST_DONE: begin
          if (ready_i) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
`ifdef MULDIV_KILL_EN
      if (kill_i && (state_reg != ST_IDLE)) begin
        state_reg <= ST_IDLE;
      end
`endif
    end
  end

  assign ready_o  = (state_reg == ST_IDLE);
  assign valid_o  = (state_reg == ST_DONE);
  assign busy_o   = (state_reg != ST_IDLE);
  assign result_o = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: transaction-level reference model plus directed vectors.
module tb_muldiv_sequencer;

  localparam logic [2:0] C_MUL    = 3'b000;
  localparam logic [2:0] C_MULH   = 3'b001;
  localparam logic [2:0] C_MULHSU = 3'b010;
  localparam logic [2:0] C_MULHU  = 3'b011;
  localparam logic [2:0] C_DIV    = 3'b100;
  localparam logic [2:0] C_DIVU   = 3'b101;
  localparam logic [2:0] C_REM    = 3'b110;
  localparam logic [2:0] C_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b1;
  logic [2:0]  op_in = 3'b000;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        kill = 1'b0;
  logic        ready_out;
  logic        valid_out;
  logic        busy_out;
  logic [31:0] result_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid_i  (valid_in),
    .ready_o  (ready_out),
    .op_i     (op_in),
    .a_i      (a_in),
    .b_i      (b_in),
    .valid_o  (valid_out),
    .ready_i  (ready_in),
    .result_o (result_out),
    .busy_o   (busy_out)
`ifdef MULDIV_KILL_EN
    ,
    .kill_i   (kill)
`endif
  );

  // Reference arithmetic from the RV32M rules, using wide native integer math.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      C_MUL:    begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      C_MULH:   begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
      C_MULHSU: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
      C_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      C_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      C_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      C_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && ((b == 0) || ((op == C_DIV || op == C_REM) &&
                                  a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Transaction model: busy from accept until the result is taken, result after a fixed latency.
  bit          m_busy  = 1'b0;
  bit          m_fresh = 1'b1;
  int          m_age   = 0;
  int          m_lat   = 0;
  logic [31:0] m_res   = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_fresh = 1'b1;
      m_age   = 0;
      m_lat   = 0;
      m_res   = '0;
    end else if (!m_busy) begin
      if (valid_in) begin
        m_busy  = 1'b1;
        m_fresh = 1'b0;
        m_age   = 1;
        m_lat   = is_special(op_in, a_in, b_in) ? 1 : 34;
        m_res   = ref_result(op_in, a_in, b_in);
      end
    end else if (kill) begin
      m_busy = 1'b0;
    end else if (m_age >= m_lat) begin
      if (ready_in) m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(posedge clk) begin
    #1;
    total++;
    if (ready_out !== !m_busy) begin
      bad++;
      $display("FAIL ready_o t=%0t got=%b want=%b", $time, ready_out, !m_busy);
    end
    total++;
    if (busy_out !== m_busy) begin
      bad++;
      $display("FAIL busy_o t=%0t got=%b want=%b", $time, busy_out, m_busy);
    end
    total++;
    if (valid_out !== (m_busy && m_age >= m_lat)) begin
      bad++;
      $display("FAIL valid_o t=%0t got=%b want=%b", $time, valid_out, m_busy && m_age >= m_lat);
    end
    if (m_busy && m_age >= m_lat) begin
      total++;
      if (result_out !== m_res) begin
        bad++;
        $display("FAIL result_o t=%0t got=%h want=%h", $time, result_out, m_res);
      end
    end else if (m_fresh) begin
      total++;
      if (result_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_result t=%0t got=%h want=00000000", $time, result_out);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int cyc;
    logic [31:0] held;
    check({name, "_model"}, ref_result(op, a, b), exp);
    @(negedge clk);
    op_in    = op;
    a_in     = a;
    b_in     = b;
    valid_in = 1'b1;
    ready_in = !hold;
    @(negedge clk);
    valid_in = 1'b0;
    op_in    = 3'($urandom);
    a_in     = $urandom;
    b_in     = $urandom;
    cyc = 1;
    while (valid_out !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_result"}, result_out, exp);
    $display("op %s a=%h b=%h result=%h cycles=%0d", name, a, b, result_out, cyc);
    if (hold) begin
      held = result_out;
      for (int i = 0; i < 10; i++) begin
        valid_in = i[0];
        @(negedge clk);
        check({name, "_hold_valid"}, 32'(valid_out), 32'd1);
        check({name, "_hold_result"}, result_out, held);
        check({name, "_hold_ready"}, 32'(ready_out), 32'd0);
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
    end
    @(negedge clk);
    check({name, "_ready_after"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready_out), 32'd1);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_result_lit", result_out, 32'h0);
    rst_n = 1'b1;

    run_op("MUL_7x6",        C_MUL,    32'd7,          32'd6,          32'd42,         34, 1'b0);
    run_op("MULHU_ffxff",    C_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34, 1'b0);
    run_op("MULH_m1x2",      C_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34, 1'b0);
    run_op("MULHSU_m1xff",   C_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34, 1'b0);
    run_op("MUL_ffxff",      C_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  34, 1'b0);
    run_op("MULH_minxmin",   C_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34, 1'b0);
    run_op("DIV_m7d2",       C_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1'b0);
    run_op("REM_m7d2",       C_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 1'b0);
    run_op("DIV_7dm2",       C_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 1'b0);
    run_op("REM_7dm2",       C_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          34, 1'b0);
    run_op("DIVU_100d7",     C_DIVU,   32'd100,        32'd7,          32'd14,         34, 1'b0);
    run_op("REMU_100d7",     C_REMU,   32'd100,        32'd7,          32'd2,          34, 1'b0);
    run_op("DIVU_bigd",      C_DIVU,   32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          34, 1'b0);
    run_op("REMU_bigd",      C_REMU,   32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34, 1'b0);
    run_op("DIVU_ffd1",      C_DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 1'b0);
    run_op("DIV_5d0",        C_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b0);
    run_op("REMU_5d0",       C_REMU,   32'd5,          32'd0,          32'd5,          1,  1'b0);
    run_op("DIV_ovf",        C_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0);
    run_op("REM_ovf",        C_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1,  1'b0);
    run_op("MUL_hold",       C_MUL,    32'd12,         32'd11,         32'd132,        34, 1'b1);

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    op_in = C_DIVU; a_in = 32'd1000; b_in = 32'd3; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready_out), 32'd1);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_result", result_out, 32'h0);
    $display("op DIVU_reset a=000003e8 b=00000003 aborted at cycle 15");
    rst_n = 1'b1;
    run_op("MUL_3x3",        C_MUL,    32'd3,          32'd3,          32'd9,          34, 1'b0);

`ifdef MULDIV_KILL_EN
    @(negedge clk);
    op_in = C_DIVU; a_in = 32'd1000; b_in = 32'd3; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (19) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_ready", 32'(ready_out), 32'd1);
    check("kill_valid", 32'(valid_out), 32'd0);
    repeat (20) @(negedge clk);
    check("kill_no_result", 32'(valid_out), 32'd0);
    $display("op DIVU_kill a=000003e8 b=00000003 killed at cycle 20");
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
